// File: rtl/ntp_seconds_sequencer.sv
// ntp_seconds_sequencer: loads integer NTP seconds into the NTP clock write port
// at a safe point in the second (one PPS edge plus a settle delay after the request).
// Latency: writeStrobe follows the sysPpsToggle edge by SETTLE_CYCLES+2 sysClk cycles.
// Backpressure: cpuReady/gpsReady are asserted only while IDLE, to the granted requester.
//
// Optional build macro: NTP_SEQ_VERIFY_EN adds a VERIFY state that checks the
// written value against sysSeconds after the following PPS edge.
//
// Ports:
//   sysClk, sysReset          clock, asynchronous active-high reset
//   cpuValid/cpuSeconds/cpuReady   host CPU request (valid/ready)
//   gpsValid/gpsSeconds/gpsReady   GPS/NMEA parser request (valid/ready)
//   sysPpsToggle              toggles once per validated PPS
//   ntpStatus                 bit0 ppsValid, bit1 secondsValid
//   sysSeconds                current seconds readback (verify build only)
//   clearErrors               pulse, clears sticky error bits
//   writeStrobe/writeData     registered single-cycle write to the NTP clock
//   busy, status              sequencing state and sticky errors
module ntp_seconds_sequencer #(
  parameter int unsigned CLK_RATE        = 100000000,
  parameter int unsigned SETTLE_CYCLES   = CLK_RATE / 10,
  parameter int unsigned TIMEOUT_SECONDS = 3
) (
  input  logic        sysClk,
  input  logic        sysReset,
  input  logic        cpuValid,
  input  logic [31:0] cpuSeconds,
  output logic        cpuReady,
  input  logic        gpsValid,
  input  logic [31:0] gpsSeconds,
  output logic        gpsReady,
  input  logic        sysPpsToggle,
  input  logic [31:0] ntpStatus,
  input  logic [31:0] sysSeconds,
  input  logic        clearErrors,
  output logic        writeStrobe,
  output logic [31:0] writeData,
  output logic        busy,
  output logic [31:0] status
);

  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_SECONDS * CLK_RATE;
  localparam logic [31:0] TIMEOUT_LOAD   = TIMEOUT_CYCLES - 1;
  localparam logic [31:0] SETTLE_LOAD    = SETTLE_CYCLES - 1;

  // lastGrant encoding: 0 = CPU, 1 = GPS
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_GPS = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PPS = 3'd1,
    S_SETTLE   = 3'd2,
    S_WRITE    = 3'd3,
    S_VERIFY   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        toggleD1_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] latched_q, latched_d;
  logic        lastGrant_q, lastGrant_d;
  logic        hasGrant_q, hasGrant_d;
  logic        timeoutErr_q, timeoutErr_d;
  logic        noPpsErr_q, noPpsErr_d;
  logic [7:0]  writeCount_q, writeCount_d;
  logic        writeStrobe_q, writeStrobe_d;
  logic [31:0] writeData_q, writeData_d;

  logic        ppsEdge;
  logic        ppsValid;
  logic        grantCpu;
  logic        grantGps;
  logic        setTimeout;
  logic        setNoPps;
  logic        verifyBit;
  logic [1:0]  stateCode;

`ifdef NTP_SEQ_VERIFY_EN
  logic        verifyErr_q, verifyErr_d;
  logic        armed_q, armed_d;   // PPS edge seen, comparison pending
  logic        dly_q, dly_d;       // one extra cycle before comparing
  logic        setVerify;
  logic        unused_status;
  assign unused_status = ^ntpStatus[31:1];
`else
  logic        unused_inputs;
  assign unused_inputs = ^{ntpStatus[31:1], sysSeconds};
`endif

  assign ppsEdge  = sysPpsToggle ^ toggleD1_q;
  assign ppsValid = ntpStatus[0];

  // Round-robin: a lone requester always wins; on a tie the one not granted last wins.
  assign grantCpu = cpuValid && (!gpsValid || (lastGrant_q == GRANT_GPS));
  assign grantGps = gpsValid && (!cpuValid || (lastGrant_q == GRANT_CPU));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    latched_d     = latched_q;
    lastGrant_d   = lastGrant_q;
    hasGrant_d    = hasGrant_q;
    writeCount_d  = writeCount_q;
    writeStrobe_d = 1'b0;
    writeData_d   = writeData_q;
    cpuReady      = 1'b0;
    gpsReady      = 1'b0;
    setTimeout    = 1'b0;
    setNoPps      = 1'b0;
`ifdef NTP_SEQ_VERIFY_EN
    armed_d       = armed_q;
    dly_d         = dly_q;
    setVerify     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cpuReady = grantCpu;
        gpsReady = grantGps;
        if (grantCpu || grantGps) begin
          latched_d   = grantCpu ? cpuSeconds : gpsSeconds;
          lastGrant_d = grantGps ? GRANT_GPS : GRANT_CPU;
          hasGrant_d  = 1'b1;
          // Without a valid PPS there is no safe point to write at: drop it.
          if (!ppsValid) begin
            setNoPps = 1'b1;
          end else begin
            state_d = S_WAIT_PPS;
            cnt_d   = TIMEOUT_LOAD;
          end
        end
      end

      S_WAIT_PPS: begin
        // The edge takes priority over a simultaneous timeout expiry.
        if (ppsEdge) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else if (cnt_q == 32'd0) begin
          setTimeout = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_SETTLE: begin
        // Further PPS edges are ignored here; the sequence is never restarted.
        if (!ppsValid) begin
          setNoPps = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == 32'd0) begin
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_WRITE: begin
        writeStrobe_d = 1'b1;
        writeData_d   = latched_q;
        writeCount_d  = writeCount_q + 8'd1;
`ifdef NTP_SEQ_VERIFY_EN
        state_d = S_VERIFY;
        cnt_d   = TIMEOUT_LOAD;
        armed_d = 1'b0;
        dly_d   = 1'b0;
`else
        state_d = S_IDLE;
`endif
      end

`ifdef NTP_SEQ_VERIFY_EN
      S_VERIFY: begin
        if (!armed_q) begin
          if (ppsEdge) begin
            armed_d = 1'b1;
            dly_d   = 1'b1;
          end else if (cnt_q == 32'd0) begin
            setTimeout = 1'b1;
            state_d    = S_IDLE;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end else if (dly_q) begin
          dly_d = 1'b0;
        end else begin
          // Two cycles after the edge the clock must show the written second plus one.
          if (sysSeconds != (latched_q + 32'd1)) begin
            setVerify = 1'b1;
          end
          armed_d = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Sticky errors: a new error in the same cycle as clearErrors survives.
    timeoutErr_d = (timeoutErr_q && !clearErrors) || setTimeout;
    noPpsErr_d   = (noPpsErr_q   && !clearErrors) || setNoPps;
`ifdef NTP_SEQ_VERIFY_EN
    verifyErr_d  = (verifyErr_q  && !clearErrors) || setVerify;
`endif
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state_q       <= S_IDLE;
      toggleD1_q    <= 1'b0;
      cnt_q         <= 32'd0;
      latched_q     <= 32'd0;
      lastGrant_q   <= GRANT_GPS;
      hasGrant_q    <= 1'b0;
      timeoutErr_q  <= 1'b0;
      noPpsErr_q    <= 1'b0;
      writeCount_q  <= 8'd0;
      writeStrobe_q <= 1'b0;
      writeData_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      toggleD1_q    <= sysPpsToggle;
      cnt_q         <= cnt_d;
      latched_q     <= latched_d;
      lastGrant_q   <= lastGrant_d;
      hasGrant_q    <= hasGrant_d;
      timeoutErr_q  <= timeoutErr_d;
      noPpsErr_q    <= noPpsErr_d;
      writeCount_q  <= writeCount_d;
      writeStrobe_q <= writeStrobe_d;
      writeData_q   <= writeData_d;
    end
  end

`ifdef NTP_SEQ_VERIFY_EN
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      verifyErr_q <= 1'b0;
      armed_q     <= 1'b0;
      dly_q       <= 1'b0;
    end else begin
      verifyErr_q <= verifyErr_d;
      armed_q     <= armed_d;
      dly_q       <= dly_d;
    end
  end
  assign verifyBit = verifyErr_q;
`else
  assign verifyBit = 1'b0;
`endif

  // WRITE and VERIFY share code 3 in the status word.
  assign stateCode = (state_q == S_VERIFY) ? 2'd3 : state_q[1:0];

  assign writeStrobe = writeStrobe_q;
  assign writeData   = writeData_q;
  assign busy        = (state_q != S_IDLE);

  // The arbiter starts out treating GPS as last granted so the CPU wins the first tie,
  // but status reports lastGrant only once a real grant has happened, so it reads 0
  // out of reset.
  assign status = {14'd0,
                   stateCode,
                   writeCount_q,
                   3'd0,
                   verifyBit,
                   noPpsErr_q,
                   timeoutErr_q,
                   lastGrant_q & hasGrant_q,
                   busy};

endmodule

// File: tb/tb_ntp_seconds_sequencer.sv
module tb_ntp_seconds_sequencer;

  localparam int CLK_RATE        = 1000;
  localparam int SETTLE_CYCLES   = 8;
  localparam int TIMEOUT_SECONDS = 1;
  localparam int S               = SETTLE_CYCLES;

  logic        sysClk;
  logic        sysReset;
  logic        cpuValid;
  logic [31:0] cpuSeconds;
  logic        cpuReady;
  logic        gpsValid;
  logic [31:0] gpsSeconds;
  logic        gpsReady;
  logic        sysPpsToggle;
  logic [31:0] ntpStatus;
  logic [31:0] sysSeconds;
  logic        clearErrors;
  logic        writeStrobe;
  logic [31:0] writeData;
  logic        busy;
  logic [31:0] status;

  int vectors;
  int miscompares;
  int strobe_cnt;

  ntp_seconds_sequencer #(
    .CLK_RATE        (CLK_RATE),
    .SETTLE_CYCLES   (SETTLE_CYCLES),
    .TIMEOUT_SECONDS (TIMEOUT_SECONDS)
  ) dut (
    .sysClk       (sysClk),
    .sysReset     (sysReset),
    .cpuValid     (cpuValid),
    .cpuSeconds   (cpuSeconds),
    .cpuReady     (cpuReady),
    .gpsValid     (gpsValid),
    .gpsSeconds   (gpsSeconds),
    .gpsReady     (gpsReady),
    .sysPpsToggle (sysPpsToggle),
    .ntpStatus    (ntpStatus),
    .sysSeconds   (sysSeconds),
    .clearErrors  (clearErrors),
    .writeStrobe  (writeStrobe),
    .writeData    (writeData),
    .busy         (busy),
    .status       (status)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  // Strobe high for one full cycle is counted exactly once.
  always @(negedge sysClk) begin
    if (writeStrobe === 1'b1) strobe_cnt++;
  end

  task automatic reset_dut();
    @(negedge sysClk);
    sysReset = 1'b1;
    cpuValid = 1'b0;
    gpsValid = 1'b0;
    clearErrors = 1'b0;
    @(negedge sysClk);
    @(negedge sysClk);
    sysReset = 1'b0;
    @(negedge sysClk);
  endtask

  // Raises valid at a negedge, waits (bounded) for ready, lets the accepting posedge
  // pass, and returns at the following negedge with valid dropped.
  task automatic do_req(input bit use_cpu, input logic [31:0] sec, input bit use_clr);
    bit seen;
    seen = 1'b0;
    @(negedge sysClk);
    if (use_cpu) begin
      cpuValid = 1'b1; cpuSeconds = sec;
    end else begin
      gpsValid = 1'b1; gpsSeconds = sec;
    end
    clearErrors = use_clr;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if ((use_cpu ? cpuReady : gpsReady) === 1'b1) seen = 1'b1;
      else @(negedge sysClk);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL req_ready: ready not seen within 20 cycles (cpu=%0d)", use_cpu);
    end
    @(posedge sysClk);
    @(negedge sysClk);
    cpuValid = 1'b0;
    gpsValid = 1'b0;
    clearErrors = 1'b0;
  endtask

  // In the verify build the sequence stays busy until the following PPS edge.
  task automatic finish_verify();
`ifdef NTP_SEQ_VERIFY_EN
    sysPpsToggle = ~sysPpsToggle;
    repeat (4) @(negedge sysClk);
`endif
  endtask

  task automatic test_reset();
    sysReset = 1'b1;
    cpuValid = 1'b0; cpuSeconds = '0;
    gpsValid = 1'b0; gpsSeconds = '0;
    sysPpsToggle = 1'b0;
    ntpStatus = 32'h3;
    sysSeconds = '0;
    clearErrors = 1'b0;
    repeat (3) @(negedge sysClk);
    sysReset = 1'b0;
    @(negedge sysClk);
    vectors++;
    if (status !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h want %h", status, 32'h0); end
    vectors++;
    if (busy !== 1'b0 || writeStrobe !== 1'b0) begin miscompares++; $display("FAIL reset_busy_strobe: busy=%b strobe=%b want 0 0", busy, writeStrobe); end
    vectors++;
    if (writeData !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", writeData); end
    vectors++;
    if (cpuReady !== 1'b0 || gpsReady !== 1'b0) begin miscompares++; $display("FAIL reset_ready: cpu=%b gps=%b want 0 0", cpuReady, gpsReady); end
  endtask

  task automatic test_cpu_write();
    int s0;
    int first;
    ntpStatus = 32'h3;
    s0 = strobe_cnt;
    first = 0;
    do_req(1'b1, 32'hE9A1_0000, 1'b0);
    vectors++;
    if (busy !== 1'b1 || status[17:16] !== 2'd1) begin miscompares++; $display("FAIL wait_state: busy=%b state=%0d want 1 1", busy, status[17:16]); end
    vectors++;
    if (status[1] !== 1'b0) begin miscompares++; $display("FAIL cpu_grant_bit: got %b want 0", status[1]); end
    sysPpsToggle = ~sysPpsToggle;
    for (int n = 1; n <= S + 6; n++) begin
      @(negedge sysClk);
      // second edge lands in SETTLE and must be ignored
      if (n == 3) sysPpsToggle = ~sysPpsToggle;
      if (n == S + 1) begin
        vectors++;
        if (status[17:16] !== 2'd3 || writeStrobe !== 1'b0) begin miscompares++; $display("FAIL write_state: state=%0d strobe=%b want 3 0", status[17:16], writeStrobe); end
      end
      if (writeStrobe === 1'b1 && first == 0) first = n;
    end
    vectors++;
    if (first != S + 2) begin miscompares++; $display("FAIL strobe_latency: got %0d want %0d", first, S + 2); end
    vectors++;
    if (strobe_cnt - s0 != 1) begin miscompares++; $display("FAIL strobe_count: got %0d want 1", strobe_cnt - s0); end
    vectors++;
    if (writeData !== 32'hE9A1_0000) begin miscompares++; $display("FAIL write_data: got %h want %h", writeData, 32'hE9A1_0000); end
    vectors++;
    if (status[15:8] !== 8'd1) begin miscompares++; $display("FAIL write_count: got %0d want 1", status[15:8]); end
    finish_verify();
    vectors++;
    if (busy !== 1'b0 || status[17:16] !== 2'd0) begin miscompares++; $display("FAIL back_idle: busy=%b state=%0d want 0 0", busy, status[17:16]); end
  endtask

  task automatic test_arbitration();
    int s0;
    bit exp_cpu;
    reset_dut();
    s0 = strobe_cnt;
    ntpStatus = 32'h0;
    cpuSeconds = 32'd1;
    gpsSeconds = 32'd2;
    cpuValid = 1'b1;
    gpsValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_cpu = (i != 1);
      vectors++;
      if (cpuReady !== exp_cpu || gpsReady !== !exp_cpu) begin miscompares++; $display("FAIL tie_grant%0d: cpu=%b gps=%b want %b %b", i, cpuReady, gpsReady, exp_cpu, !exp_cpu); end
      @(posedge sysClk);
      #1;
      vectors++;
      if (status[1] !== !exp_cpu) begin miscompares++; $display("FAIL tie_lastgrant%0d: got %b want %b", i, status[1], !exp_cpu); end
      @(negedge sysClk);
    end
    cpuValid = 1'b0;
    gpsValid = 1'b0;
    @(negedge sysClk);
    vectors++;
    if (status[3] !== 1'b1 || busy !== 1'b0 || strobe_cnt != s0) begin miscompares++; $display("FAIL tie_nopps: err=%b busy=%b strobes=%0d want 1 0 0", status[3], busy, strobe_cnt - s0); end
    clearErrors = 1'b1;
    @(negedge sysClk);
    clearErrors = 1'b0;
    vectors++;
    if (status[3] !== 1'b0) begin miscompares++; $display("FAIL tie_clear: got %b want 0", status[3]); end
  endtask

  task automatic test_timeout();
    int s0;
    ntpStatus = 32'h3;
    s0 = strobe_cnt;
    do_req(1'b0, 32'h1234_5678, 1'b0);
    for (int i = 1; i <= TIMEOUT_SECONDS * CLK_RATE; i++) begin
      @(negedge sysClk);
      if (i == TIMEOUT_SECONDS * CLK_RATE - 1) begin
        vectors++;
        if (status[2] !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL timeout_early: err=%b busy=%b want 0 1", status[2], busy); end
      end
    end
    vectors++;
    if (status[2] !== 1'b1 || busy !== 1'b0 || status[17:16] !== 2'd0) begin miscompares++; $display("FAIL timeout_set: err=%b busy=%b state=%0d want 1 0 0", status[2], busy, status[17:16]); end
    vectors++;
    if (strobe_cnt != s0 || status[1] !== 1'b1) begin miscompares++; $display("FAIL timeout_nostrobe: strobes=%0d grant=%b want 0 1", strobe_cnt - s0, status[1]); end
    clearErrors = 1'b1;
    @(negedge sysClk);
    clearErrors = 1'b0;
    vectors++;
    if (status[2] !== 1'b0) begin miscompares++; $display("FAIL timeout_clear: got %b want 0", status[2]); end
  endtask

  task automatic test_no_pps();
    int s0;
    s0 = strobe_cnt;
    ntpStatus = 32'h0;
    // error raised in the same cycle as clearErrors must survive
    do_req(1'b1, 32'd5, 1'b1);
    vectors++;
    if (status[3] !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL nopps_req: err=%b busy=%b want 1 0", status[3], busy); end
    clearErrors = 1'b1;
    @(negedge sysClk);
    clearErrors = 1'b0;
    vectors++;
    if (status[3] !== 1'b0) begin miscompares++; $display("FAIL nopps_clear: got %b want 0", status[3]); end
    ntpStatus = 32'h3;
    do_req(1'b1, 32'd6, 1'b0);
    sysPpsToggle = ~sysPpsToggle;
    repeat (3) @(negedge sysClk);
    vectors++;
    if (status[17:16] !== 2'd2) begin miscompares++; $display("FAIL nopps_settle_state: got %0d want 2", status[17:16]); end
    ntpStatus = 32'h0;
    @(negedge sysClk);
    vectors++;
    if (status[3] !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL nopps_settle_drop: err=%b busy=%b want 1 0", status[3], busy); end
    repeat (S + 4) @(negedge sysClk);
    vectors++;
    if (strobe_cnt != s0) begin miscompares++; $display("FAIL nopps_nostrobe: got %0d strobes want 0", strobe_cnt - s0); end
    ntpStatus = 32'h3;
  endtask

  task automatic test_reset_mid();
    int s0;
    s0 = strobe_cnt;
    ntpStatus = 32'h3;
    do_req(1'b0, 32'd7, 1'b0);
    sysPpsToggle = ~sysPpsToggle;
    repeat (3) @(negedge sysClk);
    vectors++;
    if (status[17:16] !== 2'd2) begin miscompares++; $display("FAIL rstmid_settle: got %0d want 2", status[17:16]); end
    sysReset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || status !== 32'h0) begin miscompares++; $display("FAIL rstmid_clear: busy=%b status=%h want 0 0", busy, status); end
    @(negedge sysClk);
    sysReset = 1'b0;
    repeat (S + 4) @(negedge sysClk);
    vectors++;
    if (strobe_cnt != s0 || status !== 32'h0 || writeData !== 32'h0) begin miscompares++; $display("FAIL rstmid_after: strobes=%0d status=%h wdata=%h want 0 0 0", strobe_cnt - s0, status, writeData); end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = strobe_cnt;
    ntpStatus = 32'h3;
    for (int i = 0; i < 256; i++) begin
      do_req(i[0], 32'h100 + i, 1'b0);
      sysPpsToggle = ~sysPpsToggle;
      repeat (S + 3) @(negedge sysClk);
      finish_verify();
      if (i == 254) begin
        vectors++;
        if (status[15:8] !== 8'd255) begin miscompares++; $display("FAIL count_255: got %0d want 255", status[15:8]); end
      end
    end
    vectors++;
    if (status[15:8] !== 8'd0) begin miscompares++; $display("FAIL count_wrap: got %0d want 0", status[15:8]); end
    vectors++;
    if (strobe_cnt - s0 != 256 || writeData !== 32'h1FF) begin miscompares++; $display("FAIL b2b_strobes: strobes=%0d wdata=%h want 256 1ff", strobe_cnt - s0, writeData); end
  endtask

`ifdef NTP_SEQ_VERIFY_EN
  task automatic test_verify();
    clearErrors = 1'b1;
    @(negedge sysClk);
    clearErrors = 1'b0;
    do_req(1'b1, 32'd100, 1'b0);
    sysPpsToggle = ~sysPpsToggle;
    repeat (S + 3) @(negedge sysClk);
    vectors++;
    if (busy !== 1'b1 || status[17:16] !== 2'd3) begin miscompares++; $display("FAIL verify_state: busy=%b state=%0d want 1 3", busy, status[17:16]); end
    sysSeconds = 32'd101;
    sysPpsToggle = ~sysPpsToggle;
    repeat (4) @(negedge sysClk);
    vectors++;
    if (busy !== 1'b0 || status[4] !== 1'b0) begin miscompares++; $display("FAIL verify_ok: busy=%b err=%b want 0 0", busy, status[4]); end
    do_req(1'b1, 32'd100, 1'b0);
    sysPpsToggle = ~sysPpsToggle;
    repeat (S + 3) @(negedge sysClk);
    sysSeconds = 32'd105;
    sysPpsToggle = ~sysPpsToggle;
    repeat (4) @(negedge sysClk);
    vectors++;
    if (busy !== 1'b0 || status[4] !== 1'b1) begin miscompares++; $display("FAIL verify_bad: busy=%b err=%b want 0 1", busy, status[4]); end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    strobe_cnt = 0;
    test_reset();
    test_cpu_write();
    test_arbitration();
    test_timeout();
    test_no_pps();
    test_reset_mid();
    test_back_to_back();
`ifdef NTP_SEQ_VERIFY_EN
    test_verify();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
